// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared constants for the common-data-bus arbiter.
//   DataWidth     - result value / PC width
//   ROBIDBus      - ROB tag width
//   CDBFifoDepth  - entries per source FIFO
//   CDBSrcALU/LSB - encoding of CDB_src and of the round-robin state
package cdb_arbiter_pkg;

  localparam int DataWidth    = 32;
  localparam int ROBIDBus     = 4;
  localparam int CDBFifoDepth = 4;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam logic CDBSrcALU = 1'b0;
  localparam logic CDBSrcLSB = 1'b1;

  // Threshold at which a source is told to back off.
  function automatic int stall_level(input int depth, input int margin);
    return depth - margin;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo: per-source result FIFO feeding the CDB arbiter.
//   clk, rst   - clock, synchronous active-high reset
//   clr        - synchronous clear (flush); empties the FIFO
//   push, din  - write request and payload; accepted when not full or
//                when a pop happens in the same cycle
//   pop, dout  - pop request and head payload (dout valid when !empty)
//   count      - occupancy, log2(DEPTH)+1 bits
//   empty/full - occupancy flags
// The caller gates push/pop/clr with its own enable; this block only
// decides acceptance.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = CDBFifoDepth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rd_en = pop && !empty;
  // A full FIFO still takes a write when its head leaves this cycle.
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter putting ALU and LSB results onto the CDB.
//   clk, rst            - clock, synchronous active-high reset
//   rdy                 - global enable; all state holds when low
//   ROB_clear           - flush; drops all queued results and same-cycle strobes
//   ALU_*               - ALU result strobe and payload
//   LSB_*               - LSB result strobe and payload
//   RS_stall, LSB_stall - combinational backpressure from registered counts
//   CDB_*               - registered broadcast; jump/target forced 0 for LSB
//   overflow_err        - sticky; a strobe was dropped at a full FIFO
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = DataWidth,
  parameter int ROB_ID_WIDTH = ROBIDBus,
  parameter int FIFO_DEPTH   = CDBFifoDepth,
  parameter int STALL_MARGIN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    ROB_clear,
  input  logic                    ALU_valid,
  input  logic [ROB_ID_WIDTH-1:0] ALU_ROB_id,
  input  logic [DATA_WIDTH-1:0]   ALU_value,
  input  logic                    ALU_jump,
  input  logic [DATA_WIDTH-1:0]   ALU_target_pc,
  input  logic                    LSB_valid,
  input  logic [ROB_ID_WIDTH-1:0] LSB_ROB_id,
  input  logic [DATA_WIDTH-1:0]   LSB_value,
  output logic                    RS_stall,
  output logic                    LSB_stall,
  output logic                    CDB_valid,
  output logic [ROB_ID_WIDTH-1:0] CDB_ROB_id,
  output logic [DATA_WIDTH-1:0]   CDB_value,
  output logic                    CDB_jump,
  output logic [DATA_WIDTH-1:0]   CDB_target_pc,
  output logic                    CDB_src,
  output logic                    overflow_err
);

  localparam int AW = 2*DATA_WIDTH + ROB_ID_WIDTH + 1;
  localparam int LW = DATA_WIDTH + ROB_ID_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] STALL_AT = CW'(stall_level(FIFO_DEPTH, STALL_MARGIN));

  logic [AW-1:0] alu_din, alu_dout;
  logic [LW-1:0] lsb_din, lsb_dout;
  logic [CW-1:0] alu_count, lsb_count;
  logic          alu_empty, alu_full, lsb_empty, lsb_full;
  logic          alu_push, lsb_push, alu_pop, lsb_pop, fifo_clr;
  logic          gnt_alu, gnt_lsb, last_grant;
  logic          alu_drop, lsb_drop;

  // Payload layout: {jump, target_pc, value, rob_id} / {value, rob_id}.
  assign alu_din = {ALU_jump, ALU_target_pc, ALU_value, ALU_ROB_id};
  assign lsb_din = {LSB_value, LSB_ROB_id};

  // Grant depends only on registered emptiness, so a fresh strobe is never
  // bypassed onto the bus in its arrival cycle.
  assign gnt_alu = !alu_empty && (lsb_empty || last_grant == CDBSrcLSB);
  assign gnt_lsb = !lsb_empty && !gnt_alu;

  assign fifo_clr = rdy && ROB_clear;
  assign alu_pop  = rdy && !ROB_clear && gnt_alu;
  assign lsb_pop  = rdy && !ROB_clear && gnt_lsb;
  assign alu_push = rdy && !ROB_clear && ALU_valid;
  assign lsb_push = rdy && !ROB_clear && LSB_valid;
  assign alu_drop = alu_push && alu_full && !alu_pop;
  assign lsb_drop = lsb_push && lsb_full && !lsb_pop;

  assign RS_stall  = alu_count >= STALL_AT;
  assign LSB_stall = lsb_count >= STALL_AT;

  cdb_src_fifo #(.WIDTH(AW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (alu_push),
    .din   (alu_din),
    .pop   (alu_pop),
    .dout  (alu_dout),
    .count (alu_count),
    .empty (alu_empty),
    .full  (alu_full)
  );

  cdb_src_fifo #(.WIDTH(LW), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (lsb_push),
    .din   (lsb_din),
    .pop   (lsb_pop),
    .dout  (lsb_dout),
    .count (lsb_count),
    .empty (lsb_empty),
    .full  (lsb_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      CDB_valid     <= False;
      CDB_ROB_id    <= '0;
      CDB_value     <= '0;
      CDB_jump      <= False;
      CDB_target_pc <= '0;
      CDB_src       <= CDBSrcALU;
      last_grant    <= CDBSrcLSB;
      overflow_err  <= False;
    end else if (rdy) begin
      if (alu_drop || lsb_drop) overflow_err <= True;
      if (ROB_clear) begin
        CDB_valid  <= False;
        last_grant <= CDBSrcLSB;
      end else if (gnt_alu) begin
        CDB_valid     <= True;
        CDB_ROB_id    <= alu_dout[ROB_ID_WIDTH-1:0];
        CDB_value     <= alu_dout[ROB_ID_WIDTH +: DATA_WIDTH];
        CDB_target_pc <= alu_dout[ROB_ID_WIDTH+DATA_WIDTH +: DATA_WIDTH];
        CDB_jump      <= alu_dout[AW-1];
        CDB_src       <= CDBSrcALU;
        last_grant    <= CDBSrcALU;
      end else if (gnt_lsb) begin
        CDB_valid     <= True;
        CDB_ROB_id    <= lsb_dout[ROB_ID_WIDTH-1:0];
        CDB_value     <= lsb_dout[ROB_ID_WIDTH +: DATA_WIDTH];
        CDB_target_pc <= '0;
        CDB_jump      <= False;
        CDB_src       <= CDBSrcLSB;
        last_grant    <= CDBSrcLSB;
      end else begin
        // Idle: only the valid drops, payload fields keep their last value.
        CDB_valid <= False;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  logic        clk, rst, rdy, ROB_clear;
  logic        ALU_valid, ALU_jump, LSB_valid;
  logic [3:0]  ALU_ROB_id, LSB_ROB_id;
  logic [31:0] ALU_value, ALU_target_pc, LSB_value;
  logic        RS_stall, LSB_stall, CDB_valid, CDB_jump, CDB_src, overflow_err;
  logic [3:0]  CDB_ROB_id;
  logic [31:0] CDB_value, CDB_target_pc;

  int n_vec = 0;
  int n_err = 0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ROB_clear(ROB_clear),
    .ALU_valid(ALU_valid), .ALU_ROB_id(ALU_ROB_id), .ALU_value(ALU_value),
    .ALU_jump(ALU_jump), .ALU_target_pc(ALU_target_pc),
    .LSB_valid(LSB_valid), .LSB_ROB_id(LSB_ROB_id), .LSB_value(LSB_value),
    .RS_stall(RS_stall), .LSB_stall(LSB_stall),
    .CDB_valid(CDB_valid), .CDB_ROB_id(CDB_ROB_id), .CDB_value(CDB_value),
    .CDB_jump(CDB_jump), .CDB_target_pc(CDB_target_pc), .CDB_src(CDB_src),
    .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // id < 0 means no broadcast expected this cycle.
  task automatic chk_cdb(input string tag, input int id, input int val, input logic src);
    if (id < 0) begin
      chk({tag, ".valid"}, 32'(CDB_valid), 32'd0);
    end else begin
      chk({tag, ".valid"}, 32'(CDB_valid), 32'd1);
      chk({tag, ".id"},    32'(CDB_ROB_id), 32'(id));
      chk({tag, ".value"}, CDB_value, 32'(val));
      chk({tag, ".src"},   32'(CDB_src), 32'(src));
    end
  endtask

  task automatic idle();
    ALU_valid = 0; ALU_ROB_id = 0; ALU_value = 0; ALU_jump = 0; ALU_target_pc = 0;
    LSB_valid = 0; LSB_ROB_id = 0; LSB_value = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  initial begin
    logic [7:0] sa, sl;
    logic [8:0] ovl;
    int ov_exp[14];
    int ai, li, k, eid;
    sa  = 8'b0101_0111;
    sl  = 8'b1010_1011;
    ovl = 9'b0_0100_0111;
    ov_exp = '{-1, 0, 12, 1, 13, 2, 14, 3, 15, 4, 5, 6, 7, -1};

    rdy = 1; ROB_clear = 0; idle();
    rst = 1; tick(); tick();
    // Reset values
    chk("rst.valid", 32'(CDB_valid), 0);
    chk("rst.id", 32'(CDB_ROB_id), 0);
    chk("rst.value", CDB_value, 0);
    chk("rst.jump", 32'(CDB_jump), 0);
    chk("rst.tpc", CDB_target_pc, 0);
    chk("rst.src", 32'(CDB_src), 0);
    chk("rst.ovf", 32'(overflow_err), 0);
    chk("rst.rs_stall", 32'(RS_stall), 0);
    chk("rst.lsb_stall", 32'(LSB_stall), 0);
    rst = 0;

    // Single ALU result: captured, then broadcast, then idle with payload held
    ALU_valid = 1; ALU_ROB_id = 3; ALU_value = 32'h1234; ALU_jump = 1; ALU_target_pc = 32'h80;
    tick(); idle();
    chk_cdb("single.e1", -1, 0, 0);
    tick();
    chk_cdb("single.e2", 3, 32'h1234, 0);
    chk("single.jump", 32'(CDB_jump), 1);
    chk("single.tpc", CDB_target_pc, 32'h80);
    tick();
    chk_cdb("single.e3", -1, 0, 0);
    chk("single.hold_id", 32'(CDB_ROB_id), 3);

    // Simultaneous sources after reset: ALU wins the first tie
    do_reset();
    ALU_valid = 1; ALU_ROB_id = 1; ALU_value = 32'h11; ALU_jump = 1; ALU_target_pc = 32'h90;
    LSB_valid = 1; LSB_ROB_id = 2; LSB_value = 32'h22;
    tick(); idle();
    chk_cdb("simul.e1", -1, 0, 0);
    tick();
    chk_cdb("simul.e2", 1, 32'h11, 0);
    chk("simul.e2.jump", 32'(CDB_jump), 1);
    tick();
    chk_cdb("simul.e3", 2, 32'h22, 1);
    chk("simul.e3.jump", 32'(CDB_jump), 0);
    chk("simul.e3.tpc", CDB_target_pc, 0);
    tick();
    chk_cdb("simul.e4", -1, 0, 0);

    // Sustained dual load, sources honouring backpressure; strict alternation
    ai = 0; li = 0;
    for (int i = 0; i < 11; i++) begin
      ALU_valid = (i < 8) ? sa[i] : 1'b0;
      ALU_ROB_id = 4'(ai); ALU_value = 32'(32'hA0 + ai);
      LSB_valid = (i < 8) ? sl[i] : 1'b0;
      LSB_ROB_id = 4'(8 + li); LSB_value = 32'(32'hB0 + li);
      tick();
      if (ALU_valid) ai++;
      if (LSB_valid) li++;
      idle();
      k = i + 1;
      if (k == 1)          chk_cdb($sformatf("dual.e%0d", k), -1, 0, 0);
      else if (k % 2 == 0) chk_cdb($sformatf("dual.e%0d", k), (k-2)/2, 32'hA0 + (k-2)/2, 0);
      else                 chk_cdb($sformatf("dual.e%0d", k), 8 + (k-3)/2, 32'hB0 + (k-3)/2, 1);
      if (i == 1) begin
        chk("dual.e2.rs_stall", 32'(RS_stall), 0);
        chk("dual.e2.lsb_stall", 32'(LSB_stall), 1);
      end
      if (i == 2) begin
        chk("dual.e3.rs_stall", 32'(RS_stall), 1);
        chk("dual.e3.lsb_stall", 32'(LSB_stall), 0);
      end
    end
    chk("dual.ovf", 32'(overflow_err), 0);

    // Overflow: ALU fills while LSB keeps winning alternate cycles
    li = 0;
    for (int i = 0; i < 14; i++) begin
      ALU_valid = (i < 9);
      ALU_ROB_id = 4'(i); ALU_value = 32'(32'h300 + i);
      LSB_valid = (i < 9) ? ovl[i] : 1'b0;
      LSB_ROB_id = 4'(12 + li); LSB_value = 32'(32'h400 + 12 + li);
      tick();
      if (LSB_valid) li++;
      idle();
      eid = ov_exp[i];
      chk_cdb($sformatf("ovf.e%0d", i + 1), eid,
              (eid >= 12) ? 32'h400 + eid : 32'h300 + eid, (eid >= 12));
      if (i == 7) begin
        chk("ovf.e8.flag", 32'(overflow_err), 0);
        chk("ovf.e8.rs_stall", 32'(RS_stall), 1);
      end
      if (i == 8) chk("ovf.e9.flag", 32'(overflow_err), 1);
    end

    // Flush with queued entries and a same-cycle strobe
    ALU_valid = 1; ALU_ROB_id = 1; ALU_value = 32'h501;
    LSB_valid = 1; LSB_ROB_id = 9; LSB_value = 32'h509;
    tick();
    chk_cdb("flush.e1", -1, 0, 0);
    ALU_ROB_id = 2; ALU_value = 32'h502; LSB_ROB_id = 10; LSB_value = 32'h50A;
    tick();
    chk_cdb("flush.e2", 9, 32'h509, 1);
    chk("flush.e2.rs_stall", 32'(RS_stall), 1);
    LSB_valid = 0; ALU_ROB_id = 3; ALU_value = 32'h503;
    tick();
    chk_cdb("flush.e3", 1, 32'h501, 0);
    ROB_clear = 1; ALU_ROB_id = 4; ALU_value = 32'h504;
    tick();
    ROB_clear = 0; idle();
    chk_cdb("flush.e4", -1, 0, 0);
    chk("flush.rs_stall", 32'(RS_stall), 0);
    chk("flush.lsb_stall", 32'(LSB_stall), 0);
    chk("flush.ovf_kept", 32'(overflow_err), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cdb($sformatf("flush.quiet%0d", i), -1, 0, 0);
    end
    // last_grant back at LSB: ALU wins the next tie
    ALU_valid = 1; ALU_ROB_id = 5; ALU_value = 32'h505;
    LSB_valid = 1; LSB_ROB_id = 11; LSB_value = 32'h50B;
    tick(); idle();
    chk_cdb("flush.post.e1", -1, 0, 0);
    tick();
    chk_cdb("flush.post.e2", 5, 32'h505, 0);
    tick();
    chk_cdb("flush.post.e3", 11, 32'h50B, 1);

    // rdy low freezes everything and ignores strobes
    ALU_valid = 1; ALU_ROB_id = 6; ALU_value = 32'h606;
    LSB_valid = 1; LSB_ROB_id = 12; LSB_value = 32'h60C;
    tick(); idle();
    chk_cdb("rdy.e1", -1, 0, 0);
    tick();
    chk_cdb("rdy.e2", 6, 32'h606, 0);
    rdy = 0;
    ALU_valid = 1; ALU_ROB_id = 7; ALU_value = 32'h607;
    LSB_valid = 1; LSB_ROB_id = 13; LSB_value = 32'h60D;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cdb($sformatf("rdy.frozen%0d", i), 6, 32'h606, 0);
    end
    rdy = 1; idle();
    tick();
    chk_cdb("rdy.resume", 12, 32'h60C, 1);
    tick();
    chk_cdb("rdy.drained", -1, 0, 0);
    tick();
    chk_cdb("rdy.no_ignored", -1, 0, 0);

    // Reset mid-operation discards queued entries and clears the sticky flag
    ALU_valid = 1; ALU_ROB_id = 13; ALU_value = 32'h70D;
    tick(); idle();
    rst = 1;
    tick();
    chk("rstmid.valid", 32'(CDB_valid), 0);
    chk("rstmid.id", 32'(CDB_ROB_id), 0);
    chk("rstmid.value", CDB_value, 0);
    chk("rstmid.src", 32'(CDB_src), 0);
    chk("rstmid.ovf", 32'(overflow_err), 0);
    rst = 0;
    tick();
    chk_cdb("rstmid.discard", -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
